router_sync: RTL

Synchronizer stage between the packet-control FSM and the three output FIFOs of the 1x3 router. It latches the destination address on `detect_add`, steers the FSM's single write enable to the addressed FIFO and returns that FIFO's full flag. It drives per-port valid flags from the FIFO empty flags. It also runs one watchdog per port that pulses `soft_reset_x` when a port holds valid data nobody reads for `TIMEOUT` cycles.

---
 rtl/router_sync.sv | 102 ++++++++++
 1 files changed

// File: rtl/router_sync.sv
// Router synchronizer stage: latches the destination address, steers the FSM write
// strobe to one of three FIFOs, and runs a per-port watchdog for unread data.
module router_sync #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int unsigned NPORT = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr;
  logic [NPORT-1:0] vld;
  logic [NPORT-1:0] rd;
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] soft_reset;
  logic [CNT_W-1:0] cnt [NPORT];

  assign vld  = ~{empty_2, empty_1, empty_0};
  assign rd   = {read_enb_2, read_enb_1, read_enb_0};
  assign full = {full_2, full_1, full_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  assign soft_reset_0 = soft_reset[0];
  assign soft_reset_1 = soft_reset[1];
  assign soft_reset_2 = soft_reset[2];

  // Destination address captured during header decode
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr <= 2'b00;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  // Steering decode always uses the registered address; address 3 is a dead port
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full[0];
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full[1];
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full[2];
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  // Independent per-port watchdogs; count restarts after each pulse
  always_ff @(posedge clock) begin
    for (int n = 0; n < NPORT; n++) begin
      if (!resetn || !vld[n] || rd[n]) begin
        cnt[n]        <= '0;
        soft_reset[n] <= 1'b0;
      end else if (cnt[n] == CNT_LAST) begin
        cnt[n]        <= '0;
        soft_reset[n] <= 1'b1;
      end else begin
        cnt[n]        <= cnt[n] + CNT_W'(1);
        soft_reset[n] <= 1'b0;
      end
    end
  end

endmodule
